// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Fetch-side requester for a 4-wide instruction memory. Issues sequential
//   16-byte fetches, buffers the returned instructions in a circular FIFO and
//   hands one instruction per cycle to decode. A redirect flushes buffered and
//   in-flight work and restarts fetch at redirect_pc.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   inst_address/InstMem_Read    fetch request (held stable until accepted)
//   InstMem_Ready, inst1..4_in   memory response (inst_address + 0/4/8/12)
//   redirect, redirect_pc        flush and restart fetch
//   dec_valid/dec_ready          decode handshake; dec_inst/dec_pc = head entry
//   fq_count                     entries currently stored
module inst_fetch_queue #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              inst_address,
  output logic                     InstMem_Read,
  input  logic                     InstMem_Ready,
  input  logic [31:0]              inst1_in,
  input  logic [31:0]              inst2_in,
  input  logic [31:0]              inst3_in,
  input  logic [31:0]              inst4_in,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_inst,
  output logic [31:0]              dec_pc,
  output logic [$clog2(DEPTH):0]   fq_count
);
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam int NUM_LANES = 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  fq_entry_t                     mem [DEPTH];
  logic [0:0]                    state, state_next;
  logic [31:0]                   fetch_pc;
  logic [AW-1:0]                 head, tail;
  logic [CW-1:0]                 count, count_next, free_next;
  logic                          accept, deq;
  logic [NUM_LANES-1:0][31:0]    lane_inst;
  logic [NUM_LANES-1:0][31:0]    lane_pc;

  assign lane_inst = {inst4_in, inst3_in, inst2_in, inst1_in};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane_pc
    assign lane_pc[l] = fetch_pc + 32'(4 * l);
  end

  assign InstMem_Read = (state == S_REQ);
  assign inst_address = fetch_pc;
  assign dec_valid    = (count != '0);
  assign dec_inst     = dec_valid ? mem[head].inst : '0;
  assign dec_pc       = dec_valid ? mem[head].pc   : '0;
  assign fq_count     = count;

  // A response arriving with a redirect belongs to the discarded path.
  assign accept = InstMem_Read && InstMem_Ready && !redirect;
  assign deq    = dec_valid && dec_ready;

  // Space test looks at the post-update occupancy so a request is only
  // raised when a full 4-wide response is guaranteed to fit.
  assign count_next = count + (accept ? CW'(NUM_LANES) : '0) - CW'(deq);
  assign free_next  = CW'(DEPTH) - count_next;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (free_next >= CW'(NUM_LANES)) state_next = S_REQ;
      S_REQ:   if (accept && free_next < CW'(NUM_LANES)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      state    <= S_IDLE;
      fetch_pc <= redirect_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (deq) head <= head + AW'(1);
      if (accept) begin
        tail     <= tail + AW'(NUM_LANES);
        fetch_pc <= fetch_pc + 32'd16;
      end
    end
  end

  // Storage is not reset; dec_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        mem[tail + AW'(l)].inst <= lane_inst[l];
        mem[tail + AW'(l)].pc   <= lane_pc[l];
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 16;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_address;
  logic        InstMem_Read;
  logic        InstMem_Ready;
  logic [31:0] inst1_in, inst2_in, inst3_in, inst4_in;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [$clog2(DEPTH):0] fq_count;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .inst_address(inst_address), .InstMem_Read(InstMem_Read), .InstMem_Ready(InstMem_Ready),
    .inst1_in(inst1_in), .inst2_in(inst2_in), .inst3_in(inst3_in), .inst4_in(inst4_in),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .fq_count(fq_count)
  );

  // Reference: the queue of instructions decode should see, in order.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } exp_t;
  exp_t q[$];

  typedef struct { logic [31:0] rpc; logic [31:0] first_inst; logic [31:0] next_addr; } rvec_t;
  rvec_t rv[4];

  int n_cmp = 0, n_err = 0;
  int mode = 0;      // 0: ready always, 1: random, 2: fixed wait states, 3: never ready
  int wait_n = 3, wcnt = 0, n_acc = 0;
  logic [31:0] exp_addr = RESET_PC;
  int gaps, seen, hold, a0;
  logic [31:0] tmp;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    logic rd, rdy, rdr, dv, dr;
    logic [31:0] ad, p_inst, p_pc;
    exp_t e;
    case (mode)
      0:       InstMem_Ready = 1'b1;
      1:       InstMem_Ready = 1'($urandom_range(0, 1));
      2:       InstMem_Ready = InstMem_Read && (wcnt >= wait_n);
      default: InstMem_Ready = 1'b0;
    endcase
    inst1_in = word_at(inst_address);
    inst2_in = word_at(inst_address + 32'd4);
    inst3_in = word_at(inst_address + 32'd8);
    inst4_in = word_at(inst_address + 32'd12);
    #1;
    rd = InstMem_Read; ad = inst_address; rdy = InstMem_Ready; rdr = redirect;
    dv = dec_valid; dr = dec_ready; p_inst = dec_inst; p_pc = dec_pc;
    if (rst) begin
      q.delete(); exp_addr = RESET_PC; wcnt = 0;
    end else begin
      if (rd) chk("req_addr", ad, exp_addr);
      if (dv && dr) begin
        if (q.size() == 0) chk("dec_valid_empty", 32'(dv), 32'd0);
        else begin
          e = q.pop_front();
          chk("dec_pc", p_pc, e.pc);
          chk("dec_inst", p_inst, e.inst);
        end
      end
      if (rdr) begin
        q.delete(); exp_addr = redirect_pc; wcnt = 0;
      end else if (rd && rdy) begin
        for (int k = 0; k < 4; k++) q.push_back('{inst: word_at(ad + 32'(4*k)), pc: ad + 32'(4*k)});
        exp_addr = ad + 32'd16; n_acc++; wcnt = 0;
      end else if (rd) wcnt++;
    end
    @(posedge clk); #1;
    chk("fq_count", 32'(fq_count), 32'(q.size()));
    chk("dec_valid", 32'(dec_valid), 32'(q.size() != 0));
  endtask

  task automatic wait_read(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (InstMem_Read) break;
      step();
    end
    chk("wait_read", 32'(InstMem_Read), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic redir_check(input rvec_t v);
    redirect = 1'b1; redirect_pc = v.rpc; step(); redirect = 1'b0;
    chk("redir_flush", 32'(fq_count), 32'd0);
    wait_read(5);
    chk("redir_addr", inst_address, v.rpc);
    step();
    chk("redir_dec_pc", dec_pc, v.rpc);
    chk("redir_dec_inst", dec_inst, v.first_inst);
    chk("redir_next_addr", inst_address, v.next_addr);
  endtask

  initial begin
    rv[0] = '{rpc: 32'h0000_0400, first_inst: 32'h0000_0100, next_addr: 32'h0000_0410};
    rv[1] = '{rpc: 32'h0000_1004, first_inst: 32'h0000_0401, next_addr: 32'h0000_1014};
    rv[2] = '{rpc: 32'h8000_0008, first_inst: 32'h2000_0002, next_addr: 32'h8000_0018};
    rv[3] = '{rpc: 32'hFFFF_FFF0, first_inst: 32'h3FFF_FFFC, next_addr: 32'h0000_0000};

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    InstMem_Ready = 1'b0; inst1_in = '0; inst2_in = '0; inst3_in = '0; inst4_in = '0;

    // Reset with the memory claiming ready throughout
    mode = 0;
    step(); step();
    chk("rst_read", 32'(InstMem_Read), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_count", 32'(fq_count), 32'd0);
    chk("rst_addr", inst_address, 32'h0);
    chk("rst_dec_inst", dec_inst, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    rst = 1'b0;
    wait_read(5);
    chk("first_addr", inst_address, 32'h0);

    // Streaming: zero-wait memory, decode always ready
    dec_ready = 1'b1; gaps = 0; seen = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (dec_valid) seen = 1;
      else if (seen != 0) gaps++;
    end
    chk("stream_started", 32'(seen), 32'd1);
    chk("stream_gaps", 32'(gaps), 32'd0);

    // Fill with decode stalled, then release
    do_reset(); dec_ready = 1'b0; mode = 0;
    for (int i = 0; i < 12; i++) step();
    chk("fill_count", 32'(fq_count), 32'(DEPTH));
    chk("fill_read", 32'(InstMem_Read), 32'd0);
    dec_ready = 1'b1;
    wait_read(10);
    chk("resume_count", 32'(fq_count), 32'(DEPTH - 4));
    mode = 3;
    for (int i = 0; i < 24; i++) step();
    chk("drain_count", 32'(fq_count), 32'd0);

    // Wait states: three cycles without ready, request held stable
    do_reset(); mode = 2; wait_n = 3; dec_ready = 1'b0;
    wait_read(5);
    a0 = n_acc; hold = 0;
    for (int i = 0; i < 12; i++) begin
      if (n_acc != a0) break;
      if (InstMem_Read) hold++;
      step();
    end
    chk("wait_read_cycles", 32'(hold), 32'd4);
    chk("wait_enq", 32'(fq_count), 32'd4);

    // Redirect over a queue holding 0x20..0x3C, then table of redirect targets
    do_reset(); mode = 0; dec_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h20; step(); redirect = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (fq_count == 8) break;
      step();
    end
    chk("t5_fill", 32'(fq_count), 32'd8);
    chk("t5_head_pc", dec_pc, 32'h20);
    chk("t5_pending_read", 32'(InstMem_Read), 32'd1);
    for (int v = 0; v < 4; v++) redir_check(rv[v]);
    dec_ready = 1'b1; mode = 3;
    for (int i = 0; i < 8; i++) step();
    chk("wrap_drain", 32'(fq_count), 32'd0);

    // Randomized traffic against the scoreboard
    do_reset(); mode = 1;
    for (int i = 0; i < 3000; i++) begin
      dec_ready = ($urandom_range(0, 3) != 0) || (i % 200 > 150);
      if (i % 200 > 100 && i % 200 <= 150) dec_ready = 1'b0;
      redirect = ($urandom_range(0, 39) == 0);
      tmp = $urandom();
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFE0 | (tmp & 32'h1C);
      else redirect_pc = tmp & ~32'h3;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; redirect = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
